// File: rtl/sync_trig_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sync_trig_master                                           |
// | Description : Master side of a multi-channel trigger handshake. A round  |
// |               waits for every enabled responder to be ready, raises      |
// |               sync_trig until all of them have dropped ready (accepted), |
// |               then waits for all of them to re-arm. Each phase is        |
// |               guarded by a timeout that aborts the round and reports     |
// |               the offending channels.                                    |
// | Options     : define SYNC_TRIG_AUTO_EN to add a periodic auto-request    |
// |               generator (ports auto_en, auto_period).                    |
// | Ports       : clk50        system clock, rising edge                     |
// |               rst          synchronous active-high reset                 |
// |               trig_req     one-cycle round request                       |
// |               ch_mask      enabled channels, captured at round start     |
// |               syncr_rdy    asynchronous responder ready levels           |
// |               auto_en      (option) enable periodic requests             |
// |               auto_period  (option) request period in cycles, 0 = off    |
// |               sync_trig    registered trigger level to responders        |
// |               busy         round in progress                             |
// |               done         one-cycle pulse, round completed              |
// |               err_tmo      one-cycle pulse, round aborted on timeout     |
// |               err_ch       channels blamed for the last aborted round    |
// |               req_drop     one-cycle pulse, a request was ignored        |
// |               trig_cnt     successful round count, wraps at 16 bits      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sync_trig_master #(
  parameter int N_CH    = 4,
  parameter int TMO_W   = 20,
  parameter int TMO_CYC = 500000
) (
  input  logic            clk50,
  input  logic            rst,
  input  logic            trig_req,
  input  logic [N_CH-1:0] ch_mask,
  input  logic [N_CH-1:0] syncr_rdy,
`ifdef SYNC_TRIG_AUTO_EN
  input  logic            auto_en,
  input  logic [23:0]     auto_period,
`endif
  output logic            sync_trig,
  output logic            busy,
  output logic            done,
  output logic            err_tmo,
  output logic [N_CH-1:0] err_ch,
  output logic            req_drop,
  output logic [15:0]     trig_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_TRIG = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  // Timer value on the last allowed cycle of a phase, and its saturation cap.
  localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TMO_CYC - 1);
  localparam logic [TMO_W-1:0] c_tmo_sat  = TMO_W'(TMO_CYC);

  // ---------------------------------------------------------------------
  // Registers (power-up values match the reset values)
  // ---------------------------------------------------------------------
  logic [N_CH-1:0]  sync1_q     = '0;
  logic [N_CH-1:0]  rdy_s_q     = '0;
  state_t           state_q     = S_IDLE;
  logic [N_CH-1:0]  mask_q      = '0;
  logic [TMO_W-1:0] timer_q     = '0;
  logic             sync_trig_q = 1'b0;
  logic             busy_q      = 1'b0;
  logic             done_q      = 1'b0;
  logic             err_tmo_q   = 1'b0;
  logic [N_CH-1:0]  err_ch_q    = '0;
  logic             req_drop_q  = 1'b0;
  logic [15:0]      trig_cnt_q  = '0;

  state_t           state_d;
  logic [N_CH-1:0]  mask_d;
  logic [TMO_W-1:0] timer_d;
  logic             sync_trig_d;
  logic             busy_d;
  logic             done_d;
  logic             err_tmo_d;
  logic [N_CH-1:0]  err_ch_d;
  logic             req_drop_d;
  logic [15:0]      trig_cnt_d;

  logic             w_auto_req;
  logic             w_req;
  logic [N_CH-1:0]  w_enabled_rdy;
  logic             w_all_rdy;
  logic             w_none_rdy;
  logic             w_tmo_hit;
  logic [TMO_W-1:0] w_timer_inc;

  // ---------------------------------------------------------------------
  // Optional periodic request generator
  // ---------------------------------------------------------------------
`ifdef SYNC_TRIG_AUTO_EN
  logic [23:0] per_cnt_q = '0;
  logic [23:0] per_cnt_d;

  always_comb begin
    w_auto_req = 1'b0;
    per_cnt_d  = '0;
    if (auto_en && (auto_period != 24'd0)) begin
      // >= rather than == so a period shortened on the fly still wraps.
      if (per_cnt_q >= (auto_period - 24'd1)) begin
        w_auto_req = 1'b1;
        per_cnt_d  = '0;
      end else begin
        per_cnt_d  = per_cnt_q + 24'd1;
      end
    end
  end
`else
  assign w_auto_req = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    w_req         = trig_req | w_auto_req;
    w_enabled_rdy = rdy_s_q & mask_q;
    w_all_rdy     = (w_enabled_rdy == mask_q);
    w_none_rdy    = (w_enabled_rdy == '0);
    w_tmo_hit     = (timer_q == c_tmo_last);
    w_timer_inc   = (timer_q >= c_tmo_sat) ? c_tmo_sat : timer_q + 1'b1;

    state_d     = state_q;
    mask_d      = mask_q;
    timer_d     = timer_q;
    sync_trig_d = sync_trig_q;
    err_ch_d    = err_ch_q;
    trig_cnt_d  = trig_cnt_q;
    done_d      = 1'b0;
    err_tmo_d   = 1'b0;

    // Any request that cannot start a round is reported, never queued.
    req_drop_d  = w_req & ((state_q != S_IDLE) | (ch_mask == '0));

    case (state_q)
      S_IDLE: begin
        if (w_req && (ch_mask != '0)) begin
          mask_d   = ch_mask;
          timer_d  = '0;
          err_ch_d = '0;
          state_d  = S_ARM;
        end
      end

      S_ARM: begin
        // Exit is tested before the timeout so a late success still wins.
        if (w_all_rdy) begin
          sync_trig_d = 1'b1;
          timer_d     = '0;
          state_d     = S_TRIG;
        end else if (w_tmo_hit) begin
          err_tmo_d   = 1'b1;
          sync_trig_d = 1'b0;
          err_ch_d    = mask_q & ~rdy_s_q;
          timer_d     = '0;
          state_d     = S_IDLE;
        end else begin
          timer_d     = w_timer_inc;
        end
      end

      S_TRIG: begin
        // Responders acknowledge the trigger by dropping ready.
        if (w_none_rdy) begin
          sync_trig_d = 1'b0;
          timer_d     = '0;
          state_d     = S_WAIT;
        end else if (w_tmo_hit) begin
          err_tmo_d   = 1'b1;
          sync_trig_d = 1'b0;
          err_ch_d    = mask_q & rdy_s_q;
          timer_d     = '0;
          state_d     = S_IDLE;
        end else begin
          timer_d     = w_timer_inc;
        end
      end

      S_WAIT: begin
        if (w_all_rdy) begin
          done_d      = 1'b1;
          trig_cnt_d  = trig_cnt_q + 16'd1;
          timer_d     = '0;
          state_d     = S_IDLE;
        end else if (w_tmo_hit) begin
          err_tmo_d   = 1'b1;
          sync_trig_d = 1'b0;
          err_ch_d    = mask_q & ~rdy_s_q;
          timer_d     = '0;
          state_d     = S_IDLE;
        end else begin
          timer_d     = w_timer_inc;
        end
      end

      default: begin
        sync_trig_d = 1'b0;
        timer_d     = '0;
        state_d     = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // ---------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk50) begin
    if (rst) begin
      sync1_q     <= '0;
      rdy_s_q     <= '0;
      state_q     <= S_IDLE;
      mask_q      <= '0;
      timer_q     <= '0;
      sync_trig_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_tmo_q   <= 1'b0;
      err_ch_q    <= '0;
      req_drop_q  <= 1'b0;
      trig_cnt_q  <= '0;
`ifdef SYNC_TRIG_AUTO_EN
      per_cnt_q   <= '0;
`endif
    end else begin
      // Two-flop synchronizer; only rdy_s_q is used by the control logic.
      sync1_q     <= syncr_rdy;
      rdy_s_q     <= sync1_q;
      state_q     <= state_d;
      mask_q      <= mask_d;
      timer_q     <= timer_d;
      sync_trig_q <= sync_trig_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_tmo_q   <= err_tmo_d;
      err_ch_q    <= err_ch_d;
      req_drop_q  <= req_drop_d;
      trig_cnt_q  <= trig_cnt_d;
`ifdef SYNC_TRIG_AUTO_EN
      per_cnt_q   <= per_cnt_d;
`endif
    end
  end

  assign sync_trig = sync_trig_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_tmo   = err_tmo_q;
  assign err_ch    = err_ch_q;
  assign req_drop  = req_drop_q;
  assign trig_cnt  = trig_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_trig_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sync_trig_master                                        |
// | Description : Bench for sync_trig_master: behavioural responders, a      |
// |               round-level reference model compared every cycle, and     |
// |               directed plus randomized scenarios.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sync_trig_master;

  localparam int N_CH    = 4;
  localparam int TMO_CYC = 100;

  logic        clk50     = 1'b0;
  logic        rst       = 1'b1;
  logic        trig_req  = 1'b0;
  logic [3:0]  ch_mask   = 4'h0;
  logic [3:0]  syncr_rdy = 4'hF;
`ifdef SYNC_TRIG_AUTO_EN
  logic        auto_en     = 1'b0;
  logic [23:0] auto_period = 24'd0;
`endif
  logic        sync_trig;
  logic        busy;
  logic        done;
  logic        err_tmo;
  logic [3:0]  err_ch;
  logic        req_drop;
  logic [15:0] trig_cnt;

  always #10 clk50 = ~clk50;

  sync_trig_master #(
    .N_CH    (N_CH),
    .TMO_W   (20),
    .TMO_CYC (TMO_CYC)
  ) dut (
    .clk50       (clk50),
    .rst         (rst),
    .trig_req    (trig_req),
    .ch_mask     (ch_mask),
    .syncr_rdy   (syncr_rdy),
`ifdef SYNC_TRIG_AUTO_EN
    .auto_en     (auto_en),
    .auto_period (auto_period),
`endif
    .sync_trig   (sync_trig),
    .busy        (busy),
    .done        (done),
    .err_tmo     (err_tmo),
    .err_ch      (err_ch),
    .req_drop    (req_drop),
    .trig_cnt    (trig_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Responders: mode 0 = well behaved, 1 = stuck not-ready, 2 = stuck ready.
  // A well-behaved responder drops ready r_drop cycles after seeing the
  // trigger and re-raises it r_rearm cycles later once the trigger is gone.
  // ---------------------------------------------------------------------
  int r_mode  [4] = '{0, 0, 0, 0};
  int r_drop  [4] = '{3, 3, 3, 3};
  int r_rearm [4] = '{20, 20, 20, 20};
  int r_st    [4] = '{0, 0, 0, 0};
  int r_cnt   [4] = '{0, 0, 0, 0};

  initial begin
    forever begin
      @(negedge clk50);
      for (int i = 0; i < 4; i++) begin
        if (r_mode[i] == 1) begin
          syncr_rdy[i] = 1'b0; r_st[i] = 0; r_cnt[i] = 0;
        end else if (r_mode[i] == 2) begin
          syncr_rdy[i] = 1'b1; r_st[i] = 0; r_cnt[i] = 0;
        end else if (r_st[i] == 0) begin
          syncr_rdy[i] = 1'b1;
          if (sync_trig) begin
            r_cnt[i]++;
            if (r_cnt[i] >= r_drop[i]) begin
              syncr_rdy[i] = 1'b0; r_st[i] = 1; r_cnt[i] = 0;
            end
          end else begin
            r_cnt[i] = 0;
          end
        end else begin
          r_cnt[i]++;
          if (r_cnt[i] >= r_rearm[i] && !sync_trig) begin
            syncr_rdy[i] = 1'b1; r_st[i] = 0; r_cnt[i] = 0;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Reference model. A round is described by the phase it is in and how
  // many cycles it has already spent in that phase; the ready levels it
  // sees are the pin values from two clock edges earlier.
  // ---------------------------------------------------------------------
  localparam int PH_NONE = 0, PH_GATHER = 1, PH_FIRE = 2, PH_REARM = 3;

  int          m_phase   = PH_NONE;
  int          m_elapsed = 0;
  int          m_auto    = 0;
  logic [3:0]  m_mask    = 4'h0;
  logic [3:0]  m_err     = 4'h0;
  logic        m_sync    = 1'b0;
  logic        m_done    = 1'b0;
  logic        m_tmo     = 1'b0;
  logic        m_drop    = 1'b0;
  logic [15:0] m_cnt     = 16'h0;
  logic [3:0]  seen1     = 4'h0;
  logic [3:0]  seen2     = 4'h0;

  task automatic abort_round(input logic [3:0] culprits);
    m_tmo     = 1'b1;
    m_sync    = 1'b0;
    m_err     = culprits;
    m_phase   = PH_NONE;
    m_elapsed = 0;
  endtask

  task automatic model_step();
    logic [3:0] rs;
    logic       req;
    rs    = seen2;
    seen2 = seen1;
    seen1 = syncr_rdy;
    req   = trig_req;
`ifdef SYNC_TRIG_AUTO_EN
    if (rst || !auto_en || auto_period == 24'd0) begin
      m_auto = 0;
    end else if (m_auto + 1 >= int'(auto_period)) begin
      req    = 1'b1;
      m_auto = 0;
    end else begin
      m_auto++;
    end
`endif
    m_done = 1'b0;
    m_tmo  = 1'b0;
    m_drop = 1'b0;
    if (rst) begin
      m_phase = PH_NONE; m_elapsed = 0; m_mask = 4'h0; m_err = 4'h0;
      m_sync = 1'b0; m_cnt = 16'h0; seen1 = 4'h0; seen2 = 4'h0;
      return;
    end
    if (req && (m_phase != PH_NONE || ch_mask == 4'h0)) m_drop = 1'b1;
    case (m_phase)
      PH_NONE: begin
        if (req && ch_mask != 4'h0) begin
          m_mask = ch_mask; m_err = 4'h0; m_phase = PH_GATHER; m_elapsed = 0;
        end
      end
      PH_GATHER: begin
        if ((rs & m_mask) == m_mask) begin
          m_sync = 1'b1; m_phase = PH_FIRE; m_elapsed = 0;
        end else if (m_elapsed + 1 >= TMO_CYC) begin
          abort_round(m_mask & ~rs);
        end else begin
          m_elapsed++;
        end
      end
      PH_FIRE: begin
        if ((rs & m_mask) == 4'h0) begin
          m_sync = 1'b0; m_phase = PH_REARM; m_elapsed = 0;
        end else if (m_elapsed + 1 >= TMO_CYC) begin
          abort_round(m_mask & rs);
        end else begin
          m_elapsed++;
        end
      end
      default: begin
        if ((rs & m_mask) == m_mask) begin
          m_done = 1'b1; m_cnt = m_cnt + 16'd1; m_phase = PH_NONE; m_elapsed = 0;
        end else if (m_elapsed + 1 >= TMO_CYC) begin
          abort_round(m_mask & ~rs);
        end else begin
          m_elapsed++;
        end
      end
    endcase
  endtask

  // Single compare process: model advances on each edge, DUT sampled 1 ns later.
  initial begin
    forever begin
      @(posedge clk50);
      model_step();
      #1;
      check("cyc_sync_trig", sync_trig, m_sync);
      check("cyc_busy",      busy,      (m_phase != PH_NONE));
      check("cyc_done",      done,      m_done);
      check("cyc_err_tmo",   err_tmo,   m_tmo);
      check("cyc_req_drop",  req_drop,  m_drop);
      check("cyc_err_ch",    err_ch,    m_err);
      check("cyc_trig_cnt",  trig_cnt,  m_cnt);
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  task automatic set_all(input int mode, input int dly, input int rearm);
    for (int i = 0; i < 4; i++) begin
      r_mode[i] = mode; r_drop[i] = dly; r_rearm[i] = rearm;
    end
  endtask

  task automatic pulse_req(input logic [3:0] mask);
    @(negedge clk50);
    trig_req = 1'b1;
    ch_mask  = mask;
    @(negedge clk50);
    trig_req = 1'b0;
  endtask

  // Runs until the round ends, counting done and err_tmo pulses.
  task automatic run_to_idle(input string name, output int nd, output int nt);
    int k;
    nd = 0; nt = 0; k = 0;
    while (busy && k < 400) begin
      @(negedge clk50);
      if (done) nd++;
      if (err_tmo) nt++;
      k++;
    end
    check({name, "_reached_idle"}, busy, 1'b0);
  endtask

  task automatic wait_trig(input logic level, input int budget, input string name);
    int k;
    k = 0;
    while (sync_trig !== level && k < budget) begin
      @(negedge clk50);
      k++;
    end
    check(name, sync_trig, level);
  endtask

  initial begin
    #1_800_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, nt, k;

    // Reset
    repeat (3) @(negedge clk50);
    rst = 1'b0;
    check("rst_sync_trig", sync_trig, 1'b0);
    check("rst_busy",      busy,      1'b0);
    check("rst_trig_cnt",  trig_cnt,  16'd0);
    check("rst_err_ch",    err_ch,    4'd0);
    repeat (4) @(negedge clk50);

    // 1: all four channels, latency and single completion
    @(negedge clk50);
    trig_req = 1'b1; ch_mask = 4'hF;
    @(negedge clk50);
    trig_req = 1'b0;
    check("t1_busy_next", busy, 1'b1);
    check("t1_trig_early", sync_trig, 1'b0);
    @(negedge clk50);
    check("t1_trig_latency2", sync_trig, 1'b1);
    run_to_idle("t1", nd, nt);
    check("t1_done_count", nd, 1);
    check("t1_no_tmo", nt, 0);
    check("t1_trig_cnt", trig_cnt, 16'd1);

    // 2: channel 1 stuck low but disabled
    r_mode[1] = 1;
    repeat (4) @(negedge clk50);
    pulse_req(4'b0101);
    run_to_idle("t2", nd, nt);
    check("t2_done_count", nd, 1);
    check("t2_no_tmo", nt, 0);
    check("t2_trig_cnt", trig_cnt, 16'd2);
    r_mode[1] = 0;
    repeat (30) @(negedge clk50);

    // 3: channel 2 never accepts the trigger
    r_mode[2] = 2;
    repeat (4) @(negedge clk50);
    pulse_req(4'hF);
    wait_trig(1'b1, 10, "t3_trig_rise");
    k = 0;
    while (!err_tmo && k < 300) begin
      @(negedge clk50);
      k++;
    end
    check("t3_tmo_after_cycles", k, TMO_CYC);
    check("t3_err_ch", err_ch, 4'b0100);
    check("t3_trig_low", sync_trig, 1'b0);
    check("t3_trig_cnt_kept", trig_cnt, 16'd2);
    r_mode[2] = 0;
    repeat (40) @(negedge clk50);

    // 4: requests while in the re-arm phase and with an empty mask
    pulse_req(4'hF);
    wait_trig(1'b1, 10, "t4_trig_rise");
    wait_trig(1'b0, 50, "t4_trig_fall");
    trig_req = 1'b1;
    @(negedge clk50);
    trig_req = 1'b0;
    check("t4_drop_in_wait", req_drop, 1'b1);
    check("t4_still_busy", busy, 1'b1);
    run_to_idle("t4", nd, nt);
    check("t4_done_count", nd, 1);
    check("t4_trig_cnt", trig_cnt, 16'd3);
    check("t4_err_ch_cleared", err_ch, 4'd0);
    pulse_req(4'h0);
    check("t4_drop_mask0", req_drop, 1'b1);
    check("t4_idle_mask0", busy, 1'b0);

    // 5: reset while the trigger is high
    repeat (4) @(negedge clk50);
    pulse_req(4'hF);
    wait_trig(1'b1, 10, "t5_trig_rise");
    rst = 1'b1;
    @(negedge clk50);
    rst = 1'b0;
    check("t5_trig_dropped", sync_trig, 1'b0);
    check("t5_no_done", done, 1'b0);
    check("t5_no_tmo", err_tmo, 1'b0);
    check("t5_trig_cnt", trig_cnt, 16'd0);
    @(negedge clk50);
    check("t5_no_done_late", done, 1'b0);
    check("t5_no_tmo_late", err_tmo, 1'b0);
    repeat (40) @(negedge clk50);

    // Randomized rounds: responder behaviour, masks, stray requests, resets
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 99) < 85) begin
          r_mode[i]  = 0;
          r_drop[i]  = int'($urandom_range(1, 5));
          r_rearm[i] = int'($urandom_range(8, 30));
        end else begin
          r_mode[i] = int'($urandom_range(1, 2));
        end
      end
      repeat (3) @(negedge clk50);
      @(negedge clk50);
      trig_req = 1'b1;
      ch_mask  = 4'($urandom_range(0, 15));
      for (int c = 0; c < 250; c++) begin
        @(negedge clk50);
        trig_req = ($urandom_range(0, 99) < 3);
        ch_mask  = 4'($urandom_range(0, 15));
        rst      = ($urandom_range(0, 999) < 3);
      end
      @(negedge clk50);
      trig_req = 1'b0;
      rst      = 1'b0;
      run_to_idle("rand", nd, nt);
    end
    set_all(0, 3, 20);
    repeat (40) @(negedge clk50);

`ifdef SYNC_TRIG_AUTO_EN
    // Auto requests every 1000 cycles with fast responders
    begin
      int dcount;
      int last_done;
      set_all(0, 1, 2);
      rst = 1'b1;
      @(negedge clk50);
      rst = 1'b0;
      ch_mask     = 4'hF;
      auto_period = 24'd1000;
      auto_en     = 1'b1;
      dcount    = 0;
      last_done = -1;
      for (int c = 0; c < 5030; c++) begin
        @(negedge clk50);
        if (done) begin
          dcount++;
          if (last_done >= 0) check("auto_done_spacing", c - last_done, 1000);
          last_done = c;
        end
      end
      check("auto_done_count", dcount, 5);
      check("auto_trig_cnt", trig_cnt, 16'd5);
      auto_en = 1'b0;
      repeat (20) @(negedge clk50);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_trig_master.md
SYNC_TRIG_MASTER -- requirements
Module: sync_trig_master

Interface
REQ-001 The module SHALL take parameter N_CH, default 4: number of responder channels.
REQ-002 The module SHALL take parameter TMO_W, default 20: timeout counter width.
REQ-003 The module SHALL take parameter TMO_CYC, default 500000: timeout limit in clk50 cycles (10 ms).
REQ-004 The module SHALL have clk50, input, 1: system clock, all logic on its rising edge.
REQ-005 The module SHALL have rst, input, 1: reset, synchronous, active-high.
REQ-006 The module SHALL have trig_req, input, 1: single-cycle request for one sync round.
REQ-007 The module SHALL have ch_mask, input, N_CH: enabled channels, sampled at round start.
REQ-008 The module SHALL have syncr_rdy, input, N_CH: per-channel responder-ready levels, asynchronous.
REQ-009 The module SHALL have sync_trig, output, 1: trigger level broadcast to all responders.
REQ-010 The module SHALL have busy, output, 1: high while a round is in progress.
REQ-011 The module SHALL have done, output, 1: one-cycle pulse when a round completes successfully.
REQ-012 The module SHALL have err_tmo, output, 1: one-cycle pulse when a round aborts on timeout.
REQ-013 The module SHALL have err_ch, output, N_CH: channels that failed the last aborted round, held until the next round starts.
REQ-014 The module SHALL have req_drop, output, 1: one-cycle pulse when trig_req is ignored.
REQ-015 The module SHALL have trig_cnt, output, 16: count of successful rounds, wraps 0xFFFF->0.

Function
REQ-016 Each syncr_rdy bit SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized value rdy_s.
REQ-017 States SHALL be S_IDLE, S_ARM, S_TRIG, S_WAIT.
REQ-018 S_IDLE: on trig_req with ch_mask!=0, the block SHALL latch ch_mask into mask_q, clear the timer and err_ch, and go to S_ARM.
REQ-019 S_ARM: when (rdy_s & mask_q)==mask_q, the block SHALL assert sync_trig on the next edge, clear the timer, and go to S_TRIG.
REQ-020 S_TRIG: sync_trig SHALL stay high until (rdy_s & mask_q)==0, meaning all enabled responders have accepted.
REQ-021 On leaving S_TRIG, the block SHALL deassert sync_trig, clear the timer, and go to S_WAIT.
REQ-022 S_WAIT: when (rdy_s & mask_q)==mask_q, meaning all enabled responders are re-armed, the block SHALL pulse done, increment trig_cnt, and go to S_IDLE.
REQ-023 The timer SHALL count in S_ARM, S_TRIG and S_WAIT and saturate at TMO_CYC.
REQ-024 When the timer reaches TMO_CYC-1 and the exit condition is still false, the block SHALL pulse err_tmo, deassert sync_trig, and go to S_IDLE.
REQ-025 On that timeout, err_ch SHALL be set to the offending channels: S_ARM/S_WAIT -> mask_q & ~rdy_s; S_TRIG -> mask_q & rdy_s.
REQ-026 If the exit condition and the timeout occur in the same cycle, the exit condition SHALL win.
REQ-027 trig_req outside S_IDLE, or with ch_mask==0, SHALL be ignored and SHALL pulse req_drop; the round in progress SHALL be unaffected.
REQ-028 Changes to ch_mask mid-round SHALL have no effect.
REQ-029 busy SHALL be 1 exactly when the state is not S_IDLE.
REQ-030 sync_trig SHALL be registered and glitch-free.
REQ-031 Latency: trig_req with all enabled channels already ready SHALL give sync_trig high 2 cycles after trig_req (S_ARM entry, then assert).

Reset
REQ-032 When rst is high, the next edge SHALL set: state S_IDLE, sync_trig 0, busy 0, done 0, err_tmo 0, req_drop 0, err_ch 0, trig_cnt 0, timer 0, synchronizers 0.
REQ-033 rst asserted mid-round SHALL drop sync_trig on the next edge with no done or err_tmo pulse.
REQ-034 All registers SHALL also have matching power-up initial values.

Configuration
REQ-035 With macro SYNC_TRIG_AUTO_EN defined, the block SHALL add input auto_en (1) and auto_period (24) and an internal period counter.
REQ-036 With SYNC_TRIG_AUTO_EN defined and auto_en=1, the block SHALL raise an internal request every auto_period cycles, OR'd with trig_req.
REQ-037 An auto request raised while busy SHALL be dropped with req_drop.
REQ-038 With SYNC_TRIG_AUTO_EN defined, auto_period==0 SHALL disable auto requests.
REQ-039 Without SYNC_TRIG_AUTO_EN, the ports and counter SHALL be absent and only trig_req SHALL start rounds.

Verification
REQ-040 The bench SHALL cover: N_CH=4, ch_mask=4'b1111, all rdy high; pulse trig_req; responders drop rdy 3 cycles after seeing sync_trig and re-raise it 20 cycles later -> sync_trig high 2 cycles after the request, one done pulse, trig_cnt=1.
REQ-041 The bench SHALL cover: ch_mask=4'b0101 with channel 1 stuck low -> round completes, channel 1 ignored.
REQ-042 The bench SHALL cover: TMO_CYC=100, channel 2 never drops rdy in S_TRIG -> err_tmo at timeout, err_ch=4'b0100, sync_trig low, trig_cnt unchanged.
REQ-043 The bench SHALL cover: trig_req during S_WAIT and trig_req with ch_mask=0 -> req_drop each time, round outcome unchanged.
REQ-044 The bench SHALL cover: rst pulsed while sync_trig is high -> sync_trig 0 next cycle, no done/err_tmo, trig_cnt 0.
REQ-045 The bench SHALL cover: SYNC_TRIG_AUTO_EN defined, auto_period=1000, fast responders -> done every 1000 cycles, trig_cnt=5 after 5000 cycles.
